// File: rtl/multi_interval_timer_if.sv
// Avalon-MM slave bus for the multi-channel interval timer: word address,
// chip select, active-low write strobe and 32-bit data with 1-cycle read latency.
interface multi_interval_timer_if #(
    parameter int AW = 4
) ();
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/multi_interval_timer.sv
// NUM_CH independent down-counting interval timers sharing one prescaler,
// each with STATUS/CONTROL/PERIOD/SNAP registers behind one Avalon-MM slave.
module multi_interval_timer #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 32,
    parameter int PRESCALE       = 1,
    parameter int DEFAULT_PERIOD = 120000 - 1,
    parameter int AW             = $clog2(NUM_CH) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_interval_timer_if.slave bus,
    output logic [NUM_CH-1:0]     irq,
    output logic                  irq_any
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic          wr_en;
    logic [1:0]    reg_sel;
    logic [31:0]   ch_idx;
    logic [31:0]   rd_next;
    logic          unused_wdata;

    logic [NUM_CH-1:0] to_q, run_q, ito_q, cont_q;
    logic [WIDTH-1:0]  period_q [NUM_CH];
    logic [WIDTH-1:0]  snap_q   [NUM_CH];

    // Free-running; with PRESCALE=1 the compare is against 0 and tick stays high.
    assign tick = (prescaler == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prescaler <= '0;
        else       prescaler <= tick ? '0 : prescaler + 1'b1;
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign reg_sel      = bus.address[1:0];
    assign ch_idx       = 32'(bus.address >> 2);
    assign unused_wdata = ^bus.writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             sel, wr_status, wr_ctrl, wr_period, wr_snap;
        logic             reload, expire;
        logic [WIDTH-1:0] counter, period, snapshot;
        logic             to, run, ito, cont;

        assign sel       = wr_en && (ch_idx == 32'(c));
        assign wr_status = sel && (reg_sel == 2'd0);
        assign wr_ctrl   = sel && (reg_sel == 2'd1);
        assign wr_period = sel && (reg_sel == 2'd2);
        assign wr_snap   = sel && (reg_sel == 2'd3);
        // The forced reload after a PERIOD write pre-empts any tick that cycle.
        assign expire    = tick && run && !reload && (counter == '0);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                counter  <= RST_PERIOD;
                period   <= RST_PERIOD;
                snapshot <= '0;
                reload   <= 1'b0;
                to       <= 1'b0;
                run      <= 1'b0;
                ito      <= 1'b0;
                cont     <= 1'b0;
            end else begin
                reload <= wr_period;
                if (wr_period) period <= bus.writedata[WIDTH-1:0];
                if (wr_snap)   snapshot <= counter;
                if (wr_ctrl) begin
                    ito  <= bus.writedata[0];
                    cont <= bus.writedata[1];
                end
                if (expire)         to <= 1'b1;
                else if (wr_status) to <= 1'b0;

                if (reload) begin
                    counter <= period;
                    run     <= 1'b0;
                end else begin
                    // A one-shot expiry parks the counter at 0 until restarted.
                    if (expire) begin
                        if (cont) counter <= period;
                        run <= cont;
                    end else if (tick && run) begin
                        counter <= counter - 1'b1;
                    end
                    if (wr_ctrl && bus.writedata[2])      run <= 1'b1;
                    else if (wr_ctrl && bus.writedata[3]) run <= 1'b0;
                end
            end
        end

        assign to_q[c]     = to;
        assign run_q[c]    = run;
        assign ito_q[c]    = ito;
        assign cont_q[c]   = cont;
        assign period_q[c] = period;
        assign snap_q[c]   = snapshot;
        assign irq[c]      = to & ito;
    end

    assign irq_any = |irq;

    // Unpopulated channel slots fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 32'(c)) begin
                case (reg_sel)
                    2'd0:    rd_next = {30'd0, run_q[c], to_q[c]};
                    2'd1:    rd_next = {30'd0, cont_q[c], ito_q[c]};
                    2'd2:    rd_next = 32'(period_q[c]);
                    default: rd_next = 32'(snap_q[c]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_next;
    end
endmodule

// File: tb/tb_multi_interval_timer.sv
// Scoreboard bench: two timer instances (4ch/PRESCALE=1 and 3ch/PRESCALE=4)
// driven with directed register sequences; a monitor checks queued expectations.
module tb_multi_interval_timer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_interval_timer_if #(.AW(4)) ifa ();
    multi_interval_timer_if #(.AW(4)) ifb ();

    logic [3:0] irq_a;
    logic       irq_any_a;
    logic [2:0] irq_b;
    logic       irq_any_b;

    multi_interval_timer #(.NUM_CH(4), .WIDTH(32), .PRESCALE(1)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (ifa.slave),
        .irq     (irq_a),
        .irq_any (irq_any_a)
    );

    multi_interval_timer #(.NUM_CH(3), .WIDTH(32), .PRESCALE(4)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (ifb.slave),
        .irq     (irq_b),
        .irq_any (irq_any_b)
    );

    // src: 0 readdata A, 1 readdata B, 2 irq A, 3 irq_any A, 4 irq B, 5 irq_any B
    typedef struct {
        int          src;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic        req         = 1'b0;
    logic        pend        = 1'b0;
    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(posedge clk) pend <= req;

    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_underflow: monitor saw a response with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.src)
                    0:       mon_act = ifa.readdata;
                    1:       mon_act = ifb.readdata;
                    2:       mon_act = 32'(irq_a);
                    3:       mon_act = 32'(irq_any_a);
                    4:       mon_act = 32'(irq_b);
                    default: mon_act = 32'(irq_any_b);
                endcase
                vectors++;
                if (mon_act !== mon_e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic bus_idle();
        ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
        ifb.chipselect = 1'b0; ifb.write_n = 1'b1;
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
        if (d == 0) begin
            ifa.address = a; ifa.writedata = v; ifa.chipselect = 1'b1; ifa.write_n = 1'b0;
        end else begin
            ifb.address = a; ifb.writedata = v; ifb.chipselect = 1'b1; ifb.write_n = 1'b0;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input int d, input logic [3:0] a, input logic [31:0] e, input string n);
        if (d == 0) begin
            ifa.address = a; ifa.chipselect = 1'b1; ifa.write_n = 1'b1;
        end else begin
            ifb.address = a; ifb.chipselect = 1'b1; ifb.write_n = 1'b1;
        end
        sb.push_back('{d, e, n});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        bus_idle();
    endtask

    task automatic chk(input int src, input logic [31:0] e, input string n);
        sb.push_back('{src, e, n});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        ifa.address = '0; ifa.writedata = '0;
        ifb.address = '0; ifb.writedata = '0;
        bus_idle();
        idle(3);
        reset = 1'b0;

        // Reset asserted while ch1 is counting
        wr(0, 4'd6, 32'd50);
        idle(1);
        wr(0, 4'd5, 32'h5);
        idle(5);
        rd(0, 4'd6, 32'd50, "pre_rst_period");
        reset = 1'b1;
        rd(0, 4'd6, 32'd0, "rst_readdata_a");
        rd(1, 4'd10, 32'd0, "rst_readdata_b");
        chk(2, 32'd0, "rst_irq_a");
        reset = 1'b0;
        rd(0, 4'd4, 32'd0, "rst_status");
        rd(0, 4'd6, 32'h1D4BF, "rst_period");
        rd(0, 4'd5, 32'd0, "rst_control");
        rd(0, 4'd7, 32'd0, "rst_snap");

        // One-shot on A ch0: timeout 10 ticks after the first running tick
        wr(0, 4'd2, 32'd9);
        idle(1);
        wr(0, 4'd1, 32'h5);
        idle(8);
        chk(2, 32'd0, "os_irq_before");
        chk(2, 32'd1, "os_irq_event");
        chk(3, 32'd1, "os_irq_any");
        rd(0, 4'd0, 32'd1, "os_status");
        wr(0, 4'd3, 32'd0);
        rd(0, 4'd3, 32'd0, "os_counter_held0");
        wr(0, 4'd0, 32'd0);
        idle(15);
        rd(0, 4'd0, 32'd0, "os_no_second_to");
        chk(2, 32'd0, "os_irq_cleared");
        wr(0, 4'd1, 32'h5);
        idle(2);
        rd(0, 4'd0, 32'd1, "os_restart_to");
        chk(2, 32'd1, "os_restart_irq");
        wr(0, 4'd0, 32'd0);

        // Snapshot on A ch3 after 100 ticks, then PERIOD write while running
        wr(0, 4'd14, 32'd1000);
        idle(1);
        wr(0, 4'd13, 32'h4);
        idle(100);
        wr(0, 4'd15, 32'd0);
        rd(0, 4'd15, 32'd900, "snap_900");
        wr(0, 4'd14, 32'd500);
        idle(1);
        wr(0, 4'd15, 32'd0);
        rd(0, 4'd15, 32'd500, "reload_counter");
        rd(0, 4'd12, 32'd0, "reload_run_clr");
        rd(0, 4'd14, 32'd500, "reload_period");

        // START|STOP together on a running channel keeps it running
        wr(0, 4'd6, 32'd1000);
        idle(1);
        wr(0, 4'd5, 32'h4);
        wr(0, 4'd5, 32'hC);
        idle(1);
        rd(0, 4'd4, 32'd2, "strobe_still_run");
        rd(0, 4'd5, 32'd0, "strobe_ctrl_read");
        wr(0, 4'd5, 32'hB);
        rd(0, 4'd4, 32'd0, "stop_status");
        rd(0, 4'd5, 32'd3, "ctrl_bits");

        // Continuous on B ch2, PRESCALE=4, PERIOD=3: event every 16 cycles
        wr(1, 4'd10, 32'd3);
        idle(1);
        wr(1, 4'd9, 32'h7);
        waited = 0;
        while (irq_b[2] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL cont_first_event: irq_b=0x%0h required 0x4 within 40 cycles", irq_b);
        end
        wr(1, 4'd8, 32'd0);
        chk(4, 32'd0, "cont_clear_between");
        idle(12);
        chk(4, 32'd0, "cont_before_event");
        chk(4, 32'd4, "cont_event_16");
        chk(5, 32'd1, "cont_irq_any");
        idle(14);
        wr(1, 4'd8, 32'd0);
        chk(4, 32'd4, "cont_clear_coincide");
        rd(1, 4'd8, 32'd3, "cont_status");

        // Channel 3 on the 3-channel instance is unpopulated
        rd(1, 4'd14, 32'd0, "dec_rd_period");
        rd(1, 4'd12, 32'd0, "dec_rd_status");
        wr(1, 4'd14, 32'h55);
        wr(1, 4'd13, 32'h7);
        wr(1, 4'd12, 32'd0);
        wr(1, 4'd15, 32'd0);
        rd(1, 4'd14, 32'd0, "dec_rd_after_wr");
        rd(1, 4'd2, 32'h1D4BF, "dec_ch0_period");
        rd(1, 4'd5, 32'd0, "dec_ch1_control");
        rd(1, 4'd10, 32'd3, "dec_ch2_period");

        idle(2);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_leftover: %0d expectations unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
